// File: rtl/systolic_ctrl_pkg.sv
// Shared defines for the systolic array control slice: array size defaults,
// precision modes, controller states and counter sizing.
package systolic_ctrl_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;

  typedef enum logic [1:0] {
    MODE_INT4  = 2'd0,
    MODE_INT8  = 2'd1,
    MODE_INT16 = 2'd2,
    MODE_RSVD  = 2'd3
  } precision_mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } ctrl_state_t;

  // One counter serves every phase: it must hold k_len-1 and ROWS+COLS-1.
  function automatic int cnt_width(int k_w, int rows, int cols);
    int fill_w;
    fill_w = $clog2(rows + cols);
    return (k_w > fill_w) ? k_w : fill_w;
  endfunction

endpackage

// File: rtl/systolic_ctrl_phase_counter.sv
// Loadable down-counter with zero flag; sequences the length of each tile phase.
module phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst)              count <= '0;
    else if (load)        count <= load_val;
    else if (dec && !zero) count <= count - W'(1);
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for an output-stationary systolic array:
// clear -> feed k_len vectors -> flush skew -> drain rows bottom-first -> done.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int K_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  input  precision_mode_t         prec_in,
  input  logic                    drain_ready,
  input  logic                    abort,
  output precision_mode_t         precision_mode,
  output logic                    acc_clear,
  output logic                    compute_enable,
  output logic                    drain_enable,
  output logic                    feed_valid,
  output logic [K_WIDTH-1:0]      feed_idx,
  output logic                    drain_valid,
  output logic [$clog2(ROWS)-1:0] drain_row,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = cnt_width(K_WIDTH, ROWS, COLS);
  localparam logic [CW-1:0] FILL_LAST = CW'(ROWS + COLS - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ROWS - 1);

  ctrl_state_t     state, state_nx;
  logic [K_WIDTH-1:0] k_q;
  precision_mode_t prec_q;
  logic            abort_clr_q, err_q;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]   cnt_val, cnt;
  logic            accept, abort_hit, hs;

  assign abort_hit      = abort && (state != IDLE);
  assign accept         = (state == IDLE) && start && !abort && (k_len != '0);
  assign hs             = (state == DRAIN) && drain_ready;
  assign precision_mode = prec_q;
  assign err            = err_q;

  phase_counter #(.W(CW)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k_q         <= '0;
      prec_q      <= MODE_INT16;
      abort_clr_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      abort_clr_q <= abort_hit;
      err_q       <= (state == IDLE) && start && !abort && (k_len == '0);
      if (accept) begin
        k_q    <= k_len;
        prec_q <= prec_in;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_load       = 1'b0;
    cnt_val        = '0;
    cnt_dec        = 1'b0;
    acc_clear      = abort_clr_q;
    compute_enable = 1'b0;
    feed_valid     = 1'b0;
    feed_idx       = '0;
    drain_enable   = 1'b0;
    drain_valid    = 1'b0;
    drain_row      = '0;
    busy           = (state != IDLE);
    done           = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_nx = CLEAR;
        cnt_load = 1'b1;
        cnt_val  = FILL_LAST;
      end
      CLEAR: begin
        cnt_dec   = 1'b1;
        acc_clear = cnt_zero;
        if (cnt_zero) begin
          state_nx = FEED;
          cnt_load = 1'b1;
          cnt_val  = CW'(k_q) - CW'(1);
        end
      end
      FEED: begin
        // counter runs k_len-1..0, so the index is its complement
        cnt_dec        = 1'b1;
        compute_enable = 1'b1;
        feed_valid     = 1'b1;
        feed_idx       = k_q - K_WIDTH'(1) - cnt[K_WIDTH-1:0];
        if (cnt_zero) begin
          state_nx = FLUSH;
          cnt_load = 1'b1;
          cnt_val  = FILL_LAST;
        end
      end
      FLUSH: begin
        cnt_dec        = 1'b1;
        compute_enable = 1'b1;
        if (cnt_zero) begin
          state_nx = DRAIN;
          cnt_load = 1'b1;
          cnt_val  = ROW_LAST;
        end
      end
      DRAIN: begin
        // count doubles as the row index: ROWS-1 down to 0, stalls on !ready
        cnt_dec      = hs;
        drain_enable = drain_ready;
        drain_valid  = drain_ready;
        drain_row    = cnt[RW-1:0];
        if (hs && cnt_zero) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_hit) begin
      state_nx = IDLE;
      cnt_load = 1'b1;
      cnt_val  = '0;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed + randomized bench for systolic_ctrl with a phase-timing reference
// and a behavioural 4x4 output-stationary array fed through the controller.
module tb_systolic_ctrl;
  import systolic_ctrl_pkg::*;

  localparam int R = 4, C = 4, KW = 16, N = R + C, NONE = -5;

  logic clk = 1'b0, rst, start, drain_ready, abort;
  logic [KW-1:0] k_len;
  precision_mode_t prec_in, precision_mode;
  logic acc_clear, compute_enable, drain_enable, feed_valid, drain_valid, busy, done, err;
  logic [KW-1:0] feed_idx;
  logic [1:0] drain_row;

  int checks = 0, errors = 0, nb = 0;
  int PAT [7] = '{1, 0, 0, 1, 1, 0, 1};

  always #5 clk = ~clk;

  systolic_ctrl #(.ROWS(R), .COLS(C), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .prec_in(prec_in),
    .drain_ready(drain_ready), .abort(abort), .precision_mode(precision_mode),
    .acc_clear(acc_clear), .compute_enable(compute_enable), .drain_enable(drain_enable),
    .feed_valid(feed_valid), .feed_idx(feed_idx), .drain_valid(drain_valid),
    .drain_row(drain_row), .busy(busy), .done(done), .err(err)
  );

  // Behavioural array: feeder emits zeros when idle, row i / col j skewed by i / j.
  int A [R][16];
  int B [16][C];
  int a_in [R], b_in [C];
  int a_sr [R][R], b_sr [C][C];
  int a_cur [R][C], b_cur [R][C];
  int ah [R][C], bv [R][C], acc [R][C], got [R][C];

  always_comb begin
    for (int i = 0; i < R; i++) a_in[i] = feed_valid ? A[i][feed_idx[3:0]] : 0;
    for (int j = 0; j < C; j++) b_in[j] = feed_valid ? B[feed_idx[3:0]][j] : 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        a_cur[i][j] = (j == 0) ? ((i == 0) ? a_in[i] : a_sr[i][i-1]) : ah[i][j-1];
        b_cur[i][j] = (i == 0) ? ((j == 0) ? b_in[j] : b_sr[j][j-1]) : bv[i-1][j];
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < R; i++) begin
      a_sr[i][0] <= a_in[i];
      for (int d = 1; d < R; d++) a_sr[i][d] <= a_sr[i][d-1];
    end
    for (int j = 0; j < C; j++) begin
      b_sr[j][0] <= b_in[j];
      for (int d = 1; d < C; d++) b_sr[j][d] <= b_sr[j][d-1];
    end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        ah[i][j] <= a_cur[i][j];
        bv[i][j] <= b_cur[i][j];
        if (acc_clear) acc[i][j] <= 0;
        else if (compute_enable) acc[i][j] <= acc[i][j] + a_cur[i][j] * b_cur[i][j];
        if (drain_enable && int'(drain_row) == i) got[i][j] <= acc[i][j];
      end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tile. Expected outputs per cycle t after accept come from the phase
  // arithmetic: CLEAR 1..N, FEED N+1..N+k, FLUSH ..2N+k, then DRAIN/DONE.
  task automatic run_tile(input int k, input precision_mode_t p, input int rmode,
                          input int abort_t, input int start_t, input int rst_t);
    int t, n, dc;
    bit fin, drn;
    logic rdy;
    @(negedge clk);
    rst = 0; start = 1; k_len = KW'(k); prec_in = p; abort = 0; drain_ready = 1;
    #1 chk("idle_busy", busy, 0);
    t = 0; n = 0; dc = 0; fin = 0; nb = 0;
    while (!fin) begin
      @(negedge clk); t++;
      start   = (t == start_t);
      k_len   = KW'($urandom_range(1, 9));
      prec_in = precision_mode_t'($urandom_range(0, 3));
      abort   = (t == abort_t);
      rst     = (t == rst_t);
      drn = (t > 2*N + k) && (n < R);
      rdy = 1'b1;
      if (rmode == 1) rdy = 1'($urandom_range(0, 1));
      else if (rmode == 2) rdy = 1'(PAT[dc % 7]);
      if (drn) dc++;
      drain_ready = rdy;
      #1;
      if (t == abort_t + 1) begin
        chk("abort_busy", busy, 0); chk("abort_clr", acc_clear, 1); chk("abort_done", done, 0);
        fin = 1;
      end else if (t == rst_t + 1) begin
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_clr", acc_clear, 0); chk("rst_ce", compute_enable, 0);
        chk("rst_fv", feed_valid, 0); chk("rst_dv", drain_valid, 0);
        chk("rst_de", drain_enable, 0); chk("rst_prec", precision_mode, MODE_INT16);
        fin = 1;
      end else if (t > 3000) begin
        checks++; errors++;
        $error("FAIL timeout: tile still busy=%0d after %0d cycles, required done", busy, t);
        fin = 1;
      end else begin
        nb++;
        chk("busy", busy, 1);
        chk("prec", precision_mode, p);
        chk("done", done, (n == R));
        chk("acc_clear", acc_clear, (t == N));
        chk("compute_en", compute_enable, (t > N && t <= 2*N + k));
        chk("feed_valid", feed_valid, (t > N && t <= N + k));
        if (t > N && t <= N + k) chk("feed_idx", feed_idx, t - N - 1);
        chk("drain_valid", drain_valid, drn && rdy);
        chk("drain_en", drain_enable, drn && rdy);
        chk("err", err, 0);
        if (drn && rdy) begin
          chk("drain_row", drain_row, R - 1 - n);
          n++;
        end
        if (!drn && n == R) fin = 1;
      end
    end
    @(negedge clk);
    start = 0; abort = 0; rst = 0; drain_ready = 0;
    #1;
    chk("post_busy", busy, 0); chk("post_done", done, 0); chk("post_clr", acc_clear, 0);
  endtask

  initial begin
    int k;
    rst = 1; start = 0; k_len = '0; prec_in = MODE_INT4; drain_ready = 0; abort = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_err", err, 0);
    chk("reset_clr", acc_clear, 0); chk("reset_ce", compute_enable, 0);
    chk("reset_fv", feed_valid, 0); chk("reset_dv", drain_valid, 0);
    chk("reset_prec", precision_mode, MODE_INT16);

    // Start in the first cycle after reset; nominal k=3 INT8 timeline.
    run_tile(3, MODE_INT8, 0, NONE, NONE, NONE);
    chk("busy_cycles_k3", nb, 24);

    // Stalling drain pattern.
    run_tile(4, MODE_INT16, 2, NONE, NONE, NONE);

    // k_len == 0 rejected with an err pulse.
    @(negedge clk); start = 1; k_len = '0; #1 chk("zk_busy0", busy, 0);
    @(negedge clk); start = 0; #1 chk("zk_err", err, 1); chk("zk_busy1", busy, 0);
    @(negedge clk); #1 chk("zk_err_off", err, 0); chk("zk_busy2", busy, 0);

    // start during FEED ignored; abort at feed_idx 1; reset in FLUSH.
    run_tile(6, MODE_INT4, 0, NONE, N + 2, NONE);
    run_tile(5, MODE_INT8, 0, N + 2, NONE, NONE);
    run_tile(4, MODE_RSVD, 0, NONE, NONE, N + 4 + 3);

    // End-to-end INT4 dot products, k=5.
    for (int i = 0; i < R; i++)
      for (int s = 0; s < 16; s++) A[i][s] = int'($urandom_range(0, 15)) - 8;
    for (int s = 0; s < 16; s++)
      for (int j = 0; j < C; j++) B[s][j] = int'($urandom_range(0, 15)) - 8;
    run_tile(5, MODE_INT4, 0, NONE, NONE, NONE);
    chk("busy_cycles_k5", nb, 2*N + 5 + R + 1);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        int dot;
        dot = 0;
        for (int s = 0; s < 5; s++) dot += A[i][s] * B[s][j];
        chk($sformatf("dot_%0d_%0d", i, j), got[i][j], dot);
      end

    // Randomized tiles with random drain back-pressure.
    repeat (4) begin
      k = $urandom_range(1, 12);
      run_tile(k, precision_mode_t'($urandom_range(0, 3)), 1, NONE, NONE, NONE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, PE rows in array.
REQ-002 SHALL have parameter COLS, default 4, PE columns in array.
REQ-003 SHALL have parameter K_WIDTH, default 16, width of reduction-length field.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request one matmul tile.
REQ-007 SHALL have port k_len  input  K_WIDTH  number of packed input vectors per tile.
REQ-008 SHALL have port prec_in  input  precision_mode_t  requested precision.
REQ-009 SHALL have port drain_ready  input  1  downstream can accept a drained row this cycle.
REQ-010 SHALL have port abort  input  1  cancel current tile.
REQ-011 SHALL have port precision_mode  output  precision_mode_t  to all PEs.
REQ-012 SHALL have ports acc_clear, compute_enable, drain_enable  output  1 each  to all PEs.
REQ-013 SHALL have ports feed_valid  output  1  and feed_idx  output  K_WIDTH  feeder fetch strobe and vector index.
REQ-014 SHALL have ports drain_valid  output  1  and drain_row  output  $clog2(ROWS)  row index leaving the bottom of the array.
REQ-015 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-016 SHALL implement states IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
REQ-017 IDLE: start=1 with k_len!=0 SHALL latch k_len and prec_in and go to CLEAR next cycle; start with k_len==0 SHALL pulse err one cycle and stay IDLE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 CLEAR SHALL last exactly ROWS+COLS cycles, with compute_enable=0 and feed_valid=0, so PE input/weight pipelines fill with zeros; acc_clear SHALL be 1 only on the last CLEAR cycle.
REQ-020 FEED SHALL last exactly k_len cycles, with feed_valid=1 and feed_idx counting 0..k_len-1.
REQ-021 FLUSH SHALL last exactly ROWS+COLS cycles, with feed_valid=0.
REQ-022 compute_enable SHALL be 1 in every FEED and FLUSH cycle and 0 elsewhere.
REQ-023 The feeder contract is zeros on all array inputs when feed_valid=0; the controller SHALL rely on this and SHALL NOT gate the PE data paths.
REQ-024 DRAIN SHALL complete exactly ROWS transfers, with drain_enable = drain_valid = drain_ready (combinational AND, in DRAIN only).
REQ-025 drain_row SHALL be ROWS-1-n for the n-th accepted transfer (bottom row first).
REQ-026 drain_ready=0 SHALL stall DRAIN indefinitely without losing a row.
REQ-027 After the ROWS-th accepted transfer, the FSM SHALL go to DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 precision_mode SHALL hold the latched value from the start-accept cycle until IDLE is re-entered, and SHALL NOT change mid-tile.
REQ-029 busy SHALL be 1 in all states except IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL, next cycle, enter IDLE with acc_clear=1 for that one cycle and no done pulse.
REQ-031 abort SHALL win over start and drain handshake when simultaneous.
REQ-032 A tile SHALL occupy exactly 2*(ROWS+COLS)+k_len+ROWS+1 busy cycles when drain_ready=1 throughout.
REQ-033 Counters SHALL be sized so that k_len = 2^K_WIDTH-1 does not wrap before FEED ends.

Reset
REQ-034 rst=1 at a clock edge SHALL force state IDLE, all counters 0, precision_mode=MODE_INT16, and all strobes/status outputs 0, overriding all other inputs, including mid-tile.
REQ-035 The first start SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-036 precision_mode_t (MODE_INT4/INT8/INT16/RSVD) and ctrl_state_t SHALL live in the shared defines package; ROWS and COLS defaults SHALL come from the shared array constants.
REQ-037 One sub-module, phase_counter (loadable down-counter with zero flag, width parameter), SHALL be instantiated for the CLEAR/FEED/FLUSH/DRAIN phase lengths.

Verification
REQ-038 ROWS=COLS=4, k_len=3, INT8, drain_ready=1: start at cycle 0 -> acc_clear at cycle 8, feed_valid cycles 9-11 (idx 0,1,2), compute_enable cycles 9-19, drain_row 3,2,1,0 at cycles 20-23, done at cycle 24, busy for 24 cycles.
REQ-039 drain_ready toggling 1,0,0,1,1,0,1 in DRAIN -> exactly 4 transfers, drain_row monotonic 3..0, done one cycle after the 4th.
REQ-040 start with k_len=0 -> err pulse, busy stays 0; start while in FEED -> ignored, feed_idx sequence unchanged.
REQ-041 abort in FEED at feed_idx=1 -> next cycle IDLE, acc_clear=1 for one cycle, done never asserts.
REQ-042 rst asserted in FLUSH -> next cycle all outputs 0, precision_mode=MODE_INT16; prec_in change during a tile -> precision_mode unchanged until IDLE.
REQ-043 End-to-end with a 4x4 pe array, INT4 packed data, k_len=5 -> drained rows equal the software dot products.
